blinker_sched: RTL

BLINKER_SCHED -- requirements
Module: blinker_sched

---
 rtl/blinker_sched_pkg.sv | 18 +
 rtl/blinker_sched_tick.sv | 26 ++
 rtl/blinker_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/blinker_sched_pkg.sv
// Shared types and widths for the blinker burst scheduler.
package blinker_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GID_W = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/blinker_sched_tick.sv
// Free-running prescaler: tick_o is high one cycle in every TICK_DIV.
module blinker_sched_tick #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic system1000,
    input  logic system1000_rst,
    output logic tick_o
);

    localparam int unsigned W = $clog2(TICK_DIV);

    logic [W-1:0] cnt_q;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            cnt_q <= '0;
        end else if (cnt_q == W'(TICK_DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tick_o = (cnt_q == W'(TICK_DIV - 1));

endmodule

// File: rtl/blinker_sched.sv
// Round-robin LED blink-burst scheduler. Define BLINKER_SCHED_PRIO_EN to give
// requester 0 absolute priority over the round-robin group.
module blinker_sched
    import blinker_sched_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned ON_TICKS  = 250,
    parameter int unsigned OFF_TICKS = 250,
    parameter int unsigned GAP_TICKS = 1000
) (
    input  logic                  system1000,
    input  logic                  system1000_rst,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*CNT_W-1:0] req_count_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  led_o,
    output logic                  busy_o,
    output logic [GID_W-1:0]      grant_id_o
);

`ifdef BLINKER_SCHED_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    localparam int unsigned TMAX = max_u(max_u(ON_TICKS, OFF_TICKS),
                                         max_u(GAP_TICKS, (1 << CNT_W) - 1));
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [TW-1:0]      rem_q, rem_d;
    logic [GID_W-1:0]   last_q, last_d;
    logic [GID_W-1:0]   gid_q, gid_d;
    logic               led_q, led_d;
    logic               tick;
    logic               found;
    logic [GID_W-1:0]   winner;
    logic [CNT_W-1:0]   win_count;
    logic               transfer;

    blinker_sched_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .system1000    (system1000),
        .system1000_rst(system1000_rst),
        .tick_o        (tick)
    );

    // Requester 0 is pre-empted into the priority slot, so the RR scan skips it.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        if (PRIO_EN && req_valid_i[0]) begin
            found = 1'b1;
        end
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned idx;
            idx = (32'(last_q) + k) % NREQ;
            if (!found && !(PRIO_EN && idx == 0) && 1'(req_valid_i >> idx)) begin
                found  = 1'b1;
                winner = GID_W'(idx);
            end
        end
    end

    assign win_count   = CNT_W'(req_count_i >> (CNT_W * winner));
    assign req_ready_o = (state_q == ST_IDLE && found && !system1000_rst)
                         ? ({{(NREQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign transfer    = |req_ready_o;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        last_d  = last_q;
        gid_d   = gid_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    gid_d  = winner;
                    last_d = winner;
                    if (win_count != '0) begin
                        state_d = ST_ON;
                        rem_d   = TW'(win_count);
                        timer_d = '0;
                    end
                end
            end
            ST_ON: begin
                if (tick) begin
                    if (timer_q == TW'(ON_TICKS - 1)) begin
                        state_d = ST_OFF;
                        timer_d = '0;
                        rem_d   = rem_q - TW'(1);
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (timer_q == TW'(OFF_TICKS - 1)) begin
                        state_d = (rem_q != '0) ? ST_ON : ST_GAP;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (timer_q == TW'(GAP_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        led_d = (state_d == ST_ON);
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            rem_q   <= '0;
            last_q  <= GID_W'(NREQ - 1);
            gid_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            led_q   <= led_d;
        end
    end

    assign led_o      = led_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign grant_id_o = gid_q;

endmodule
